id_ex_pipeline_register: RTL and testbench
==========================================

// Module: id_ex_pipeline_register
// PURPOSE
//   ID->EX pipeline register of the 5-stage RV32 core. Captures all decode-stage
//   data and control outputs on the rising clock edge and presents them to the
//   execute stage. Freezes its contents while the memory system stalls (BUSYWAIT).
//   Asynchronous active-low reset clears every field to a bubble (all zeros).
// PARAMETERS
//   DATA_W  32  width of PC, register operands and immediate
//   None other; all control-field widths are fixed as listed below.
// PORTS  (name  dir  width  meaning; IN_x = input field, OUT_x = registered copy)
//   CLK                     in   1   clock, rising-edge active
//   RESET                   in   1   asynchronous reset, ACTIVE-LOW (0 = clear)
//   BUSYWAIT                in   1   stall: 1 = hold all outputs, 0 = capture
//   IN_/OUT_INSTRUCTION     in/out 5  destination register index (rd)
//   IN_/OUT_PC              in/out 32 PC of the instruction
//   IN_/OUT_DATA1           in/out 32 register-file read data rs1
//   IN_/OUT_DATA2           in/out 32 register-file read data rs2
//   IN_/OUT_IMMEDIATE       in/out 32 sign-extended immediate
//   IN_/OUT_DATA1ALUSEL     in/out 2  ALU operand-1 mux select
//   IN_/OUT_DATA2ALUSEL     in/out 2  ALU operand-2 mux select
//   IN_/OUT_DATA1BJSEL      in/out 2  branch-unit operand-1 mux select
//   IN_/OUT_DATA2BJSEL      in/out 2  branch-unit operand-2 mux select
//   IN_/OUT_ALU_OP          in/out 5  ALU operation code
//   IN_/OUT_BRANCH_JUMP     in/out 3  branch/jump type
//   IN_/OUT_DATAMEMSEL      in/out 1  data-memory result select
//   IN_/OUT_READ_WRITE      in/out 4  memory read/write control
//   IN_/OUT_WB_SEL          in/out 2  write-back source select
//   IN_/OUT_REG_WRITE_EN    in/out 1  register-file write enable
//   Positional port order: IN_INSTRUCTION, IN_PC, IN_DATA1, IN_DATA2,
//   IN_IMMEDIATE, IN_DATA1ALUSEL, IN_DATA2ALUSEL, IN_DATA1BJSEL, IN_DATA2BJSEL,
//   IN_ALU_OP, IN_BRANCH_JUMP, IN_DATAMEMSEL, IN_READ_WRITE, IN_WB_SEL,
//   IN_REG_WRITE_EN, then OUT_* in same order, then CLK, RESET, BUSYWAIT.
// BEHAVIOUR
//   - All OUT_* are flops; no combinational path from IN_* to OUT_*.
//   - RESET=0: all OUT_* forced to 0 immediately (async), held while RESET=0.
//     Zero control = bubble (REG_WRITE_EN=0, READ_WRITE=0, BRANCH_JUMP=0).
//   - RESET release: first capture at the next rising CLK edge with RESET=1.
//   - Rising CLK, RESET=1, BUSYWAIT=0: every OUT_x <= IN_x (latency 1 cycle).
//   - Rising CLK, RESET=1, BUSYWAIT=1: every OUT_x holds its previous value.
//   - Priority: RESET > BUSYWAIT > capture. Reset during a stall still clears.
//   - BUSYWAIT sampled only at the clock edge; changes between edges have no
//     effect. All fields move together; never partial updates.
//   - Outputs change only at a rising CLK edge or on RESET assertion.
// TESTING
//   1 Reset: drive non-zero inputs, RESET=0 mid-cycle -> all OUT_* = 0 at once,
//     stay 0 across clock edges until RESET=1.
//   2 Capture: RESET=1, BUSYWAIT=0, IN: INSTR=15 PC=23 D1=45 D2=33 IMM=56,
//     all SELs=1, ALU_OP=15, BJ=2, DMSEL=1, RW=1, WB=01, RWEN=0 -> after next
//     rising edge OUT_* equal those values.
//   3 Stall: BUSYWAIT=1, IN: INSTR=25 PC=43 D1=55 D2=63 SELs=0 ALU_OP=30 BJ=3
//     DMSEL=0 RW=2 WB=0 -> after edge OUT_* still equal test-2 values.
//   4 Stall release: BUSYWAIT back to 0 -> next edge OUT_* = test-3 values.
//   5 Reset during stall: BUSYWAIT=1, RESET=0 -> outputs 0 immediately.
//   6 Max-width values: all-ones on every IN_* -> captured exactly, no truncation.

Source files
------------

// File: rtl/id_ex_pipeline_register.sv
// -----------------------------------------------------------------------------
// id_ex_pipeline_register
//
// ID->EX pipeline register of the 5-stage RV32 core. Every decode-stage data
// and control field is captured together on the rising clock edge and handed
// to the execute stage. While the memory system stalls (BUSYWAIT=1) the whole
// register holds. An asynchronous active-low RESET clears every field to zero,
// which the downstream stages treat as a bubble: no register write, no memory
// access and no branch.
//
// Ports
//   IN_INSTRUCTION   [4:0]         destination register index (rd)
//   IN_PC            [DATA_W-1:0]  PC of the instruction
//   IN_DATA1         [DATA_W-1:0]  rs1 read data
//   IN_DATA2         [DATA_W-1:0]  rs2 read data
//   IN_IMMEDIATE     [DATA_W-1:0]  sign-extended immediate
//   IN_DATA1ALUSEL   [1:0]         ALU operand-1 mux select
//   IN_DATA2ALUSEL   [1:0]         ALU operand-2 mux select
//   IN_DATA1BJSEL    [1:0]         branch-unit operand-1 mux select
//   IN_DATA2BJSEL    [1:0]         branch-unit operand-2 mux select
//   IN_ALU_OP        [4:0]         ALU operation code
//   IN_BRANCH_JUMP   [2:0]         branch/jump type
//   IN_DATAMEMSEL                  data-memory result select
//   IN_READ_WRITE    [3:0]         memory read/write control
//   IN_WB_SEL        [1:0]         write-back source select
//   IN_REG_WRITE_EN                register-file write enable
//   OUT_*                          registered copies of the IN_* fields
//   CLK                            clock, rising-edge active
//   RESET                          asynchronous reset, active low
//   BUSYWAIT                       1 = hold all outputs, 0 = capture
// -----------------------------------------------------------------------------
module id_ex_pipeline_register #(
   parameter int DATA_W = 32
) (
   input  logic [4:0]        IN_INSTRUCTION,
   input  logic [DATA_W-1:0] IN_PC,
   input  logic [DATA_W-1:0] IN_DATA1,
   input  logic [DATA_W-1:0] IN_DATA2,
   input  logic [DATA_W-1:0] IN_IMMEDIATE,
   input  logic [1:0]        IN_DATA1ALUSEL,
   input  logic [1:0]        IN_DATA2ALUSEL,
   input  logic [1:0]        IN_DATA1BJSEL,
   input  logic [1:0]        IN_DATA2BJSEL,
   input  logic [4:0]        IN_ALU_OP,
   input  logic [2:0]        IN_BRANCH_JUMP,
   input  logic              IN_DATAMEMSEL,
   input  logic [3:0]        IN_READ_WRITE,
   input  logic [1:0]        IN_WB_SEL,
   input  logic              IN_REG_WRITE_EN,
   output logic [4:0]        OUT_INSTRUCTION,
   output logic [DATA_W-1:0] OUT_PC,
   output logic [DATA_W-1:0] OUT_DATA1,
   output logic [DATA_W-1:0] OUT_DATA2,
   output logic [DATA_W-1:0] OUT_IMMEDIATE,
   output logic [1:0]        OUT_DATA1ALUSEL,
   output logic [1:0]        OUT_DATA2ALUSEL,
   output logic [1:0]        OUT_DATA1BJSEL,
   output logic [1:0]        OUT_DATA2BJSEL,
   output logic [4:0]        OUT_ALU_OP,
   output logic [2:0]        OUT_BRANCH_JUMP,
   output logic              OUT_DATAMEMSEL,
   output logic [3:0]        OUT_READ_WRITE,
   output logic [1:0]        OUT_WB_SEL,
   output logic              OUT_REG_WRITE_EN,
   input  logic              CLK,
   input  logic              RESET,
   input  logic              BUSYWAIT
);

   // All fields live in one packed record so capture, hold and clear always
   // act on the complete stage; a partial update cannot be written by accident.
   typedef struct packed {
      logic [4:0]        instruction;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] data1;
      logic [DATA_W-1:0] data2;
      logic [DATA_W-1:0] immediate;
      logic [1:0]        data1_alu_sel;
      logic [1:0]        data2_alu_sel;
      logic [1:0]        data1_bj_sel;
      logic [1:0]        data2_bj_sel;
      logic [4:0]        alu_op;
      logic [2:0]        branch_jump;
      logic              data_mem_sel;
      logic [3:0]        read_write;
      logic [1:0]        wb_sel;
      logic              reg_write_en;
   } stage_t;

   stage_t w_in;
   stage_t r_stage;

   assign w_in = '{
      instruction   : IN_INSTRUCTION,
      pc            : IN_PC,
      data1         : IN_DATA1,
      data2         : IN_DATA2,
      immediate     : IN_IMMEDIATE,
      data1_alu_sel : IN_DATA1ALUSEL,
      data2_alu_sel : IN_DATA2ALUSEL,
      data1_bj_sel  : IN_DATA1BJSEL,
      data2_bj_sel  : IN_DATA2BJSEL,
      alu_op        : IN_ALU_OP,
      branch_jump   : IN_BRANCH_JUMP,
      data_mem_sel  : IN_DATAMEMSEL,
      read_write    : IN_READ_WRITE,
      wb_sel        : IN_WB_SEL,
      reg_write_en  : IN_REG_WRITE_EN
   };

   // Reset outranks the stall, so a reset that arrives mid-stall still
   // injects a bubble.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         // NOTE: the all-zero reset value is what makes this a bubble; every
         // control field must clear, not only the write enables.
         r_stage <= '0;
      end else if (!BUSYWAIT) begin
         // NOTE: non-blocking so every flop samples the pre-edge inputs.
         r_stage <= w_in;
      end
   end

   assign OUT_INSTRUCTION  = r_stage.instruction;
   assign OUT_PC           = r_stage.pc;
   assign OUT_DATA1        = r_stage.data1;
   assign OUT_DATA2        = r_stage.data2;
   assign OUT_IMMEDIATE    = r_stage.immediate;
   assign OUT_DATA1ALUSEL  = r_stage.data1_alu_sel;
   assign OUT_DATA2ALUSEL  = r_stage.data2_alu_sel;
   assign OUT_DATA1BJSEL   = r_stage.data1_bj_sel;
   assign OUT_DATA2BJSEL   = r_stage.data2_bj_sel;
   assign OUT_ALU_OP       = r_stage.alu_op;
   assign OUT_BRANCH_JUMP  = r_stage.branch_jump;
   assign OUT_DATAMEMSEL   = r_stage.data_mem_sel;
   assign OUT_READ_WRITE   = r_stage.read_write;
   assign OUT_WB_SEL       = r_stage.wb_sel;
   assign OUT_REG_WRITE_EN = r_stage.reg_write_en;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipeline_register
//
// Directed bench for id_ex_pipeline_register: reset clearing, capture,
// stall hold, stall release, reset during a stall, all-ones fields and
// insensitivity to inputs and BUSYWAIT changes between clock edges.
// -----------------------------------------------------------------------------
module tb_id_ex_pipeline_register;

   localparam int DATA_W = 32;

   // Expected-value record, field order matches the port list.
   typedef struct packed {
      logic [4:0]        instruction;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] data1;
      logic [DATA_W-1:0] data2;
      logic [DATA_W-1:0] immediate;
      logic [1:0]        data1_alu_sel;
      logic [1:0]        data2_alu_sel;
      logic [1:0]        data1_bj_sel;
      logic [1:0]        data2_bj_sel;
      logic [4:0]        alu_op;
      logic [2:0]        branch_jump;
      logic              data_mem_sel;
      logic [3:0]        read_write;
      logic [1:0]        wb_sel;
      logic              reg_write_en;
   } fields_t;

   logic [4:0]        in_instruction, out_instruction;
   logic [DATA_W-1:0] in_pc, out_pc;
   logic [DATA_W-1:0] in_data1, out_data1;
   logic [DATA_W-1:0] in_data2, out_data2;
   logic [DATA_W-1:0] in_immediate, out_immediate;
   logic [1:0]        in_data1alusel, out_data1alusel;
   logic [1:0]        in_data2alusel, out_data2alusel;
   logic [1:0]        in_data1bjsel, out_data1bjsel;
   logic [1:0]        in_data2bjsel, out_data2bjsel;
   logic [4:0]        in_alu_op, out_alu_op;
   logic [2:0]        in_branch_jump, out_branch_jump;
   logic              in_datamemsel, out_datamemsel;
   logic [3:0]        in_read_write, out_read_write;
   logic [1:0]        in_wb_sel, out_wb_sel;
   logic              in_reg_write_en, out_reg_write_en;
   logic              clk = 1'b0;
   logic              reset;
   logic              busywait;

   fields_t obs;
   int      total = 0;
   int      bad   = 0;

   id_ex_pipeline_register #(.DATA_W(DATA_W)) dut (
      .IN_INSTRUCTION   (in_instruction),
      .IN_PC            (in_pc),
      .IN_DATA1         (in_data1),
      .IN_DATA2         (in_data2),
      .IN_IMMEDIATE     (in_immediate),
      .IN_DATA1ALUSEL   (in_data1alusel),
      .IN_DATA2ALUSEL   (in_data2alusel),
      .IN_DATA1BJSEL    (in_data1bjsel),
      .IN_DATA2BJSEL    (in_data2bjsel),
      .IN_ALU_OP        (in_alu_op),
      .IN_BRANCH_JUMP   (in_branch_jump),
      .IN_DATAMEMSEL    (in_datamemsel),
      .IN_READ_WRITE    (in_read_write),
      .IN_WB_SEL        (in_wb_sel),
      .IN_REG_WRITE_EN  (in_reg_write_en),
      .OUT_INSTRUCTION  (out_instruction),
      .OUT_PC           (out_pc),
      .OUT_DATA1        (out_data1),
      .OUT_DATA2        (out_data2),
      .OUT_IMMEDIATE    (out_immediate),
      .OUT_DATA1ALUSEL  (out_data1alusel),
      .OUT_DATA2ALUSEL  (out_data2alusel),
      .OUT_DATA1BJSEL   (out_data1bjsel),
      .OUT_DATA2BJSEL   (out_data2bjsel),
      .OUT_ALU_OP       (out_alu_op),
      .OUT_BRANCH_JUMP  (out_branch_jump),
      .OUT_DATAMEMSEL   (out_datamemsel),
      .OUT_READ_WRITE   (out_read_write),
      .OUT_WB_SEL       (out_wb_sel),
      .OUT_REG_WRITE_EN (out_reg_write_en),
      .CLK              (clk),
      .RESET            (reset),
      .BUSYWAIT         (busywait)
   );

   always #5 clk = ~clk;

   assign obs = '{out_instruction, out_pc, out_data1, out_data2, out_immediate,
                  out_data1alusel, out_data2alusel, out_data1bjsel, out_data2bjsel,
                  out_alu_op, out_branch_jump, out_datamemsel, out_read_write,
                  out_wb_sel, out_reg_write_en};

   task automatic drive(input fields_t v);
      in_instruction  = v.instruction;
      in_pc           = v.pc;
      in_data1        = v.data1;
      in_data2        = v.data2;
      in_immediate    = v.immediate;
      in_data1alusel  = v.data1_alu_sel;
      in_data2alusel  = v.data2_alu_sel;
      in_data1bjsel   = v.data1_bj_sel;
      in_data2bjsel   = v.data2_bj_sel;
      in_alu_op       = v.alu_op;
      in_branch_jump  = v.branch_jump;
      in_datamemsel   = v.data_mem_sel;
      in_read_write   = v.read_write;
      in_wb_sel       = v.wb_sel;
      in_reg_write_en = v.reg_write_en;
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Move to the middle of the low phase, well away from any rising edge.
   task automatic mid_cycle();
      @(negedge clk);
      #2;
   endtask

   task automatic check(input string tag, input fields_t exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   fields_t v_zero;
   fields_t v_a;
   fields_t v_b;
   fields_t v_c;
   fields_t v_ones;

   initial begin
      v_zero = '0;
      // Vector from the capture test: rd=15 PC=23 D1=45 D2=33 IMM=56, SELs=1,
      // ALU_OP=15, BJ=2, DMSEL=1, RW=1, WB=01, RWEN=0.
      v_a = '{5'd15, 32'd23, 32'd45, 32'd33, 32'd56, 2'd1, 2'd1, 2'd1, 2'd1,
              5'd15, 3'd2, 1'b1, 4'd1, 2'd1, 1'b0};
      // Vector offered during the stall.
      v_b = '{5'd25, 32'd43, 32'd55, 32'd63, 32'd77, 2'd0, 2'd0, 2'd0, 2'd0,
              5'd30, 3'd3, 1'b0, 4'd2, 2'd0, 1'b1};
      // Distinct pattern used for the pre-reset load.
      v_c = '{5'd7, 32'hDEAD_BEEF, 32'h1234_5678, 32'h8765_4321, 32'hFFFF_F800,
              2'd2, 2'd3, 2'd1, 2'd2, 5'd9, 3'd5, 1'b1, 4'd10, 2'd3, 1'b1};
      v_ones = '1;

      reset    = 1'b1;
      busywait = 1'b0;
      drive(v_c);

      // Load non-zero content, then assert reset between edges.
      tick();
      check("preload", v_c);
      mid_cycle();
      reset = 1'b0;
      #1;
      check("reset_async_clear", v_zero);
      tick();
      check("reset_hold_edge1", v_zero);
      tick();
      check("reset_hold_edge2", v_zero);

      // Release reset between edges: nothing captured until the next edge.
      drive(v_a);
      mid_cycle();
      reset = 1'b1;
      #1;
      check("reset_release_no_capture", v_zero);
      tick();
      check("capture_a", v_a);

      // Inputs changing between edges must not reach the outputs.
      mid_cycle();
      drive(v_b);
      #1;
      check("no_comb_path", v_a);

      // Stall: v_b offered, v_a held across two edges.
      busywait = 1'b1;
      tick();
      check("stall_hold1", v_a);
      tick();
      check("stall_hold2", v_a);

      // Release stall: v_b captured at the next edge.
      mid_cycle();
      busywait = 1'b0;
      #1;
      check("stall_release_pre_edge", v_a);
      tick();
      check("capture_b", v_b);

      // BUSYWAIT pulse that ends before the edge has no effect.
      mid_cycle();
      drive(v_a);
      busywait = 1'b1;
      #1;
      busywait = 1'b0;
      tick();
      check("busywait_glitch_ignored", v_a);

      // Reset during a stall still clears immediately.
      mid_cycle();
      busywait = 1'b1;
      drive(v_b);
      tick();
      check("stall_before_reset", v_a);
      mid_cycle();
      reset = 1'b0;
      #1;
      check("reset_during_stall", v_zero);
      tick();
      check("reset_during_stall_edge", v_zero);

      // Release reset while still stalled: outputs stay at the bubble.
      mid_cycle();
      reset = 1'b1;
      tick();
      check("stall_after_reset", v_zero);

      // All-ones on every field: captured without truncation, then held.
      mid_cycle();
      busywait = 1'b0;
      drive(v_ones);
      tick();
      check("capture_all_ones", v_ones);
      mid_cycle();
      busywait = 1'b1;
      drive(v_zero);
      tick();
      check("hold_all_ones", v_ones);
      mid_cycle();
      busywait = 1'b0;
      tick();
      check("capture_zero_after_ones", v_zero);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
